// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by the VGA timing master and consumed by the
// pixel generators and the connector.
interface vga_timing_gen_if;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       line_start;
  logic [7:0] frame_cnt;

  modport master (
    output vga_x, vga_y, video_on, hsync, vsync, frame_start, line_start, frame_cnt
  );

  modport slave (
    input vga_x, vga_y, video_on, hsync, vsync, frame_start, line_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel timing master: raw raster counters, active-video and
// frame/line strobes, plus syncs delayed to match downstream pixel latency.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int PIPE_DLY = 2
) (
  input  logic            vga_clk,
  input  logic            sys_rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] frame_cnt;
  logic       h_end;
  logic       v_end;
  logic       hs_raw;
  logic       vs_raw;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // frame_cnt advances on the same edge that wraps the raster back to (0,0)
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      if (v_end) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign hs_raw = (h_cnt >= H_SYNC_END);
  assign vs_raw = (v_cnt >= V_SYNC_END);

  assign vga.vga_x       = h_cnt;
  assign vga.vga_y       = v_cnt;
  assign vga.frame_cnt   = frame_cnt;
  assign vga.video_on    = !sys_rst
                           && (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END)
                           && (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  assign vga.frame_start = !sys_rst && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign vga.line_start  = !sys_rst && (h_cnt == 10'd0);

  // Syncs are held inactive through reset even when there is no delay line.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign vga.hsync = hs_raw || sys_rst;
    assign vga.vsync = vs_raw || sys_rst;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] hs_pipe;
    logic [PIPE_DLY-1:0] vs_pipe;

    always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe <= PIPE_DLY'({hs_pipe, hs_raw});
        vs_pipe <= PIPE_DLY'({vs_pipe, vs_raw});
      end
    end

    assign vga.hsync = hs_pipe[PIPE_DLY-1];
    assign vga.vsync = vs_pipe[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: three geometries/delays checked
// every cycle against an arithmetic raster model, plus interval measurements.
module tb_vga_timing_gen;

  localparam int SH_SYNC = 3, SH_BP = 2, SH_ACT = 8, SH_FP = 3;
  localparam int SV_SYNC = 2, SV_BP = 2, SV_ACT = 4, SV_FP = 2;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  bit valid    = 0;
  int cyc      = 0;

  int   ls_last, hs_run, fs_last, von_cnt, vs_cnt;
  bit   hs_prev, von_prev, fc_ok, wrap_seen;
  logic [7:0] fc_prev;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_sml ();
  vga_timing_gen_if if_raw ();

  vga_timing_gen #(.PIPE_DLY(2)) dut_def (
    .vga_clk(clk), .sys_rst(rst), .vga(if_def)
  );

  vga_timing_gen #(
    .H_SYNC(SH_SYNC), .H_BP(SH_BP), .H_ACT(SH_ACT), .H_FP(SH_FP),
    .V_SYNC(SV_SYNC), .V_BP(SV_BP), .V_ACT(SV_ACT), .V_FP(SV_FP),
    .PIPE_DLY(3)
  ) dut_sml (
    .vga_clk(clk), .sys_rst(rst), .vga(if_sml)
  );

  vga_timing_gen #(
    .H_SYNC(SH_SYNC), .H_BP(SH_BP), .H_ACT(SH_ACT), .H_FP(SH_FP),
    .V_SYNC(SV_SYNC), .V_BP(SV_BP), .V_ACT(SV_ACT), .V_FP(SV_FP),
    .PIPE_DLY(0)
  ) dut_raw (
    .vga_clk(clk), .sys_rst(rst), .vga(if_raw)
  );

  logic [32:0] obs_def, obs_sml, obs_raw;
  assign obs_def = {if_def.vga_x, if_def.vga_y, if_def.video_on, if_def.hsync, if_def.vsync,
                    if_def.frame_start, if_def.line_start, if_def.frame_cnt};
  assign obs_sml = {if_sml.vga_x, if_sml.vga_y, if_sml.video_on, if_sml.hsync, if_sml.vsync,
                    if_sml.frame_start, if_sml.line_start, if_sml.frame_cnt};
  assign obs_raw = {if_raw.vga_x, if_raw.vga_y, if_raw.video_on, if_raw.hsync, if_raw.vsync,
                    if_raw.frame_start, if_raw.line_start, if_raw.frame_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Outputs after t clean cycles since the last reset edge, from raster arithmetic.
  function automatic logic [32:0] refModel(input int tt, input logic r,
      input int hsw, input int hbp, input int hact, input int hfp,
      input int vsw, input int vbp, input int vact, input int vfp, input int d);
    int ht = hsw + hbp + hact + hfp;
    int vt = vsw + vbp + vact + vfp;
    int x  = tt % ht;
    int ln = tt / ht;
    int y  = ln % vt;
    int fc = (ln / vt) % 256;
    logic von, hs, vs, fs, ls;
    von = !r && (x >= hsw + hbp) && (x < hsw + hbp + hact)
             && (y >= vsw + vbp) && (y < vsw + vbp + vact);
    if (tt >= d) begin
      hs = ((tt - d) % ht) >= hsw;
      vs = (((tt - d) / ht) % vt) >= vsw;
    end else begin
      hs = 1'b1;
      vs = 1'b1;
    end
    if (d == 0 && r) begin
      hs = 1'b1;
      vs = 1'b1;
    end
    fs = !r && (x == 0) && (y == 0);
    ls = !r && (x == 0);
    return {10'(x), 10'(y), von, hs, vs, fs, ls, 8'(fc)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearTrackers();
    ls_last  = -1;
    hs_run   = -1;
    fs_last  = -1;
    von_cnt  = 0;
    vs_cnt   = 0;
    hs_prev  = 1'b1;
    von_prev = 1'b0;
    fc_ok    = 1'b0;
  endtask

  // Drive reset for one cycle, check the settled outputs, then advance the model.
  task automatic applyStimulus(input logic r);
    @(negedge clk);
    rst = r;
    #1;
    if (valid) begin
      checkOutput("def_cycle", 64'(obs_def), 64'(refModel(t, rst, 96, 48, 640, 16, 2, 33, 480, 10, 2)));
      checkOutput("sml_cycle", 64'(obs_sml), 64'(refModel(t, rst, SH_SYNC, SH_BP, SH_ACT, SH_FP,
                                                          SV_SYNC, SV_BP, SV_ACT, SV_FP, 3)));
      checkOutput("raw_cycle", 64'(obs_raw), 64'(refModel(t, rst, SH_SYNC, SH_BP, SH_ACT, SH_FP,
                                                          SV_SYNC, SV_BP, SV_ACT, SV_FP, 0)));
      if (rst) begin
        clearTrackers();
      end else begin
        if (t == 0)
          checkOutput("post_rst_origin", {if_def.vga_x, if_def.vga_y, if_def.frame_start, if_def.line_start},
                      {10'd0, 10'd0, 1'b1, 1'b1});
        if (if_def.line_start) begin
          if (ls_last >= 0) checkOutput("def_line_period", cyc - ls_last, 800);
          ls_last = cyc;
        end
        if (!if_def.hsync) begin
          if (hs_prev) begin
            checkOutput("def_hs_fall_x", if_def.vga_x, 2);
            hs_run = 0;
          end
          if (hs_run >= 0) hs_run++;
        end else if (!hs_prev && hs_run >= 0) begin
          checkOutput("def_hs_low_len", hs_run, 96);
          hs_run = -1;
        end
        hs_prev = if_def.hsync;
        if (if_sml.frame_start) begin
          if (fs_last >= 0) begin
            checkOutput("sml_frame_period", cyc - fs_last, 160);
            checkOutput("sml_von_per_frame", von_cnt, SH_ACT * SV_ACT);
            checkOutput("sml_vs_low_per_frame", vs_cnt, SV_SYNC * 16);
          end
          fs_last = cyc;
          von_cnt = 0;
          vs_cnt  = 0;
        end
        if (fs_last >= 0) begin
          von_cnt += int'(if_sml.video_on);
          vs_cnt  += int'(!if_sml.vsync);
        end
        if (if_sml.video_on && !von_prev)
          checkOutput("sml_von_rise_x", if_sml.vga_x, SH_SYNC + SH_BP);
        von_prev = if_sml.video_on;
        if (fc_ok && if_sml.frame_cnt != fc_prev) begin
          checkOutput("sml_fc_step", {if_sml.vga_x, if_sml.vga_y, if_sml.frame_cnt},
                      {10'd0, 10'd0, 8'(fc_prev + 8'd1)});
          if (if_sml.frame_cnt == 8'd0) wrap_seen = 1'b1;
        end
        fc_prev = if_sml.frame_cnt;
        fc_ok   = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    if (rst) begin
      t     = 0;
      valid = 1'b1;
    end else if (valid) begin
      t++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    wrap_seen = 1'b0;
    clearTrackers();
    $display("[TB] start");

    applyStimulus(1'b1);
    repeat ($urandom_range(20, 400)) applyStimulus(1'b0);
    repeat (10) applyStimulus(1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        repeat ($urandom_range(1, 5)) applyStimulus(1'b1);
      else
        applyStimulus(1'b0);
    end

    // Single-cycle reset in the middle of a line flushes the sync delay line.
    applyStimulus(1'b1);
    for (int i = 0; i < 2000 && t != 400; i++) applyStimulus(1'b0);
    checkOutput("reach_400", t, 400);
    applyStimulus(1'b1);
    repeat (900) applyStimulus(1'b0);

    // Long clean run so the small raster's frame counter passes 254, 255, 0.
    applyStimulus(1'b1);
    repeat (256 * 160 + 200) applyStimulus(1'b0);
    checkOutput("sml_fc_wrapped", wrap_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing master for the 640x480@60 Hz VGA output path. Generates the raw horizontal/vertical counters (`vga_x`, `vga_y`), the active-video qualifier and per-frame strobes that the pixel generators (start screen, game screen) consume. It also produces `hsync`/`vsync` to the connector, delayed by `PIPE_DLY` cycles so they line up with the pixel generators' registered `rgb`. Coordinates are raw counter values, not active-area-relative: the active window starts at x = H_SYNC+H_BP = 144 and y = V_SYNC+V_BP = 35.

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- PIPE_DLY, 2, sync delay in cycles (0..7) matching downstream pixel latency

Ports:
- vga_clk  in  1  pixel clock (25.175/25 MHz); one clock domain; synchronous reset; active-high
- sys_rst  in  1  synchronous, active-high reset
- vga_x  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- vga_y  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- video_on  out  1  high when vga_x in [144,784) and vga_y in [35,515)
- hsync  out  1  active-low horizontal sync, delayed PIPE_DLY cycles
- vsync  out  1  active-low vertical sync, delayed PIPE_DLY cycles
- frame_start  out  1  one-cycle pulse when (vga_x,vga_y) = (0,0)
- line_start  out  1  one-cycle pulse when vga_x = 0
- frame_cnt  out  8  free-running frame counter, wraps 255->0

## Operation
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0, and v_cnt increments. v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt is at H_TOTAL-1.
- frame_cnt increments on the same cycle edge on which v_cnt wraps. 8-bit modulo arithmetic.
- `vga_x`/`vga_y` are the counter registers themselves.
- `video_on`, `frame_start` and `line_start` are decoded from the same counter state, so they are valid in the same cycle as the coordinates they describe.
- Raw sync: hs_raw = 0 when h_cnt < H_SYNC, else 1. vs_raw = 0 when v_cnt < V_SYNC, else 1.
- `hsync`/`vsync` are hs_raw/vs_raw passed through a PIPE_DLY-stage shift register. With PIPE_DLY = 0 they are the raw decode.
- Reset, applied at any point including mid-line or mid-frame:
  - counters and frame_cnt go to 0
  - every delay-line stage is loaded with 1 (inactive)
  - video_on, frame_start and line_start are forced to 0 while sys_rst is high
- No other state. There is no handshake; downstream blocks sample on every vga_clk.

## Timing
- Reset values (sys_rst high): vga_x = 0, vga_y = 0, video_on = 0, hsync = 1, vsync = 1, frame_start = 0, line_start = 0, frame_cnt = 0.
- First cycle after sys_rst falls: vga_x = 0, vga_y = 0, frame_start = 1, line_start = 1, hs_raw = 0.
  - With PIPE_DLY = 2, `hsync` first goes low 2 cycles later.
- Line period is 800 cycles. hs_raw is low for 96 cycles. video_on is high for 640 consecutive cycles per active line, first at vga_x = 144, last at vga_x = 783.
- Frame period is 525 x 800 = 420000 cycles. vs_raw is low for 1600 cycles (lines 0-1). Active lines are 35..514.
- vsync transitions coincide with hsync-raw falling edges (h_cnt = 0), both delayed identically.
- Downstream contract: a pixel generator with 2-cycle registered latency, sampling (vga_x, vga_y, video_on) at cycle t, drives rgb at t+2. `hsync`/`vsync` at t+2 correspond to counter state at t.

## Test plan
- Hold sys_rst high for 10 cycles at an arbitrary counter state -> all outputs equal reset values every cycle. First post-reset cycle shows (0,0) with frame_start = 1.
- Run 2 lines -> line_start pulses exactly 800 cycles apart. hs_raw low for exactly 96 cycles. `hsync` low interval starts 2 cycles after vga_x = 0.
- Run 1 full frame -> video_on is high for 307200 cycles. First assertion at (144,35), last at (783,514). vsync low for 1600 cycles. frame_start period is 420000.
- Run 256 frames (or force the counter near the wrap) -> frame_cnt steps 254, 255, 0 exactly at v_cnt/h_cnt wrap.
- Assert sys_rst at (400,200) for 1 cycle -> next cycle counters are (0,0). Delay line flushed: `hsync` stays 1 for 2 cycles, then goes 0.
- Instantiate with PIPE_DLY = 0 -> `hsync`/`vsync` equal the raw decode in the same cycle as the counters.
